sd_spi_master: RTL
==================

// Module: sd_spi_master
// PURPOSE
//   SPI mode-0 byte engine driving the SD card socket; the transmit/initiator end of the SD link.
//   The CPU I/O decoder strobes a byte in. The block shifts it out MSB-first on MOSI and captures the
//   simultaneous MISO byte. It raises a one-cycle done pulse when the byte is complete.
//   Sits between the Z80 port-decode logic and the SD pins; chip select is CPU-controlled.
// PARAMETERS
//   DIV_SLOW   64   clk cycles per SCLK half-period in init mode (~400 kHz at 50 MHz); must be >=1
//   DIV_FAST   2    clk cycles per SCLK half-period in data mode; must be >=1
//   CNT_W      8    width of half-period counter; must hold max(DIV_SLOW,DIV_FAST)-1
// PORTS
//   clk        in   1   system clock, all logic on rising edge
//   reset      in   1   asynchronous, active-high reset
//   wr_stb     in   1   one-cycle strobe: start transfer of wr_data
//   wr_data    in   8   byte to transmit, sampled on wr_stb
//   fast_sel   in   1   0 = DIV_SLOW, 1 = DIV_FAST; sampled at transfer start only
//   cs_ctl     in   1   1 = assert card select (drives sd_cs_n low)
//   rd_data    out  8   last received byte, stable while busy=0
//   busy       out  1   transfer in progress
//   done       out  1   one-cycle pulse at end of transfer
//   sd_cs_n    out  1   card chip select, active low, registered
//   sd_sclk    out  1   SPI clock, idle low
//   sd_mosi    out  1   SPI data out, idles high
//   sd_miso    in   1   SPI data in from card
// BEHAVIOUR
//   Reset values: busy=0, done=0, rd_data=8'hFF, sd_sclk=0, sd_mosi=1, sd_cs_n=1, state=IDLE.
//   Reset mid-transfer aborts immediately to the reset values; no done pulse.
//   sd_cs_n = ~cs_ctl, registered (1-cycle lag). It is independent of the state machine.
//   States: IDLE -> LOW -> HIGH -> (LOW | FINISH) -> IDLE.
//     IDLE: on wr_stb, load shift reg, latch div, and drive sd_mosi=wr_data[7].
//           busy=1 next cycle, bit_cnt=0, cnt=0, then go to LOW.
//     LOW: sclk=0 for div cycles (cnt counts 0..div-1), then sclk rises and go to HIGH.
//     HIGH: sample sd_miso into shift LSB on the sclk rising edge.
//           Hold sclk=1 for div cycles, then sclk falls.
//           If bit_cnt==7, go to FINISH. Else bit_cnt++, shift left, and drive the next MSB on sd_mosi.
//     FINISH: rd_data<=shift reg, done=1 for exactly one cycle, busy=0, and sd_mosi=1.
//             Return to IDLE in the same cycle.
//   Latency: wr_stb at cycle T gives busy high at T+1 and done at T+1+16*div. busy falls with done.
//   Back-to-back: wr_stb is accepted in the done cycle (busy=0), giving zero idle gap.
//   wr_stb while busy=1: ignored; no error flag.
//   Changes to fast_sel or wr_data during a transfer do not affect it.
//   div=1: sclk toggles every clk cycle (clk/2); the counter compare must still work.
//   Exactly 8 rising sclk edges per transfer. sclk is never high in IDLE.
// CONFIGURATION
//   SD_SPI_LOOPBACK_EN defined: adds input loop_en. When loop_en=1, the receive path samples sd_mosi
//     instead of sd_miso, so rd_data==wr_data. sd_sclk and sd_mosi still toggle on the pins.
//   Undefined: no loop_en port; the receive path always samples sd_miso.
// STRUCTURE
//   Shared package sd_pkg: state enum (ST_IDLE, ST_LOW, ST_HIGH, ST_FINISH) and SPI_IDLE_MOSI=1'b1.
//   Also the reset value RD_RESET=8'hFF.
//   Optional sub-module spi_halfper_cnt: loadable down-counter emitting a tick every div cycles.
//   The FSM and shift register stay in sd_spi_master.
// TESTING
//   1. Reset asserted mid-byte (after 3 sclk rises) -> next cycle sclk=0, mosi=1, cs_n=1, busy=0.
//      No done pulse follows.
//   2. fast_sel=1, DIV_FAST=2, wr_data=8'hA5, MISO model returns 8'h3C -> MOSI bits 1,0,1,0,0,1,0,1.
//      rd_data=8'h3C, done at T+33.
//   3. fast_sel=0, DIV_SLOW=64, wr_data=8'hFF -> sclk high/low 64 cycles each, done at T+1025.
//   4. Second wr_stb issued during busy, then third in the done cycle -> second ignored.
//      Third starts with zero gap; exactly 16 sclk rises total.
//   5. cs_ctl toggled 0->1->0 while idle -> sd_cs_n follows inverted with 1-cycle lag.
//      sclk stays 0.
//   6. SD_SPI_LOOPBACK_EN, loop_en=1, wr_data=8'h5A, sd_miso tied 0 -> rd_data=8'h5A.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared types and constants for the SD-card SPI byte engine.
package sd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_FINISH
    } sd_state_e;

    localparam logic       SPI_IDLE_MOSI = 1'b1;
    localparam logic [7:0] RD_RESET      = 8'hFF;

endpackage

// File: rtl/sd_spi_master_if.sv
// CPU-side byte strobe / status bundle between the Z80 port decoder and sd_spi_master.
interface sd_spi_master_if;

    logic       wr_stb;
    logic [7:0] wr_data;
    logic       fast_sel;
    logic       cs_ctl;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;

    modport master (
        output wr_stb, wr_data, fast_sel, cs_ctl,
        input  rd_data, busy, done
    );

    modport slave (
        input  wr_stb, wr_data, fast_sel, cs_ctl,
        output rd_data, busy, done
    );

endinterface

// File: rtl/spi_halfper_cnt.sv
// Loadable down-counter: ticks once every (div_m1 + 1) enabled cycles; div is latched on load.
module spi_halfper_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_div_m1,
    input  logic             i_en,
    output logic             o_tick
);

    logic [CNT_W-1:0] r_div_m1;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_div_m1 <= '0;
            r_cnt    <= '0;
        end else if (i_load) begin
            r_div_m1 <= i_div_m1;
            r_cnt    <= i_div_m1;
        end else if (i_en) begin
            if (r_cnt == '0) begin
                r_cnt <= r_div_m1;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // div=1 keeps the count at zero, so the tick fires every enabled cycle
    assign o_tick = i_en && (r_cnt == '0);

endmodule

// File: rtl/sd_spi_master.sv
// SPI mode-0 byte engine for the SD socket; MSB-first, one-cycle done pulse per byte.
// Optional SD_SPI_LOOPBACK_EN adds i_loop_en, which feeds MOSI back into the receive path.
module sd_spi_master
    import sd_pkg::*;
#(
    parameter int unsigned DIV_SLOW = 64,
    parameter int unsigned DIV_FAST = 2,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    sd_spi_master_if.slave        cpu,
`ifdef SD_SPI_LOOPBACK_EN
    input  logic                  i_loop_en,
`endif
    output logic                  o_sd_cs_n,
    output logic                  o_sd_sclk,
    output logic                  o_sd_mosi,
    input  logic                  i_sd_miso
);

    localparam logic [CNT_W-1:0] SLOW_M1 = CNT_W'(DIV_SLOW - 1);
    localparam logic [CNT_W-1:0] FAST_M1 = CNT_W'(DIV_FAST - 1);

    sd_state_e r_state;
    sd_state_e w_state_next;

    logic       w_start;
    logic       w_tick;
    logic       w_busy;
    logic       w_rx_in;
    logic       w_last;
    logic [CNT_W-1:0] w_div_m1;

    // r_shift holds the not-yet-sent TX bits above the already-received RX bits
    logic [6:0] r_shift;
    logic       r_rx_bit;
    logic [2:0] r_bit_cnt;
    logic       r_sclk;
    logic       r_mosi;
    logic       r_cs_n;
    logic [7:0] r_rd_data;

    assign w_busy   = (r_state == ST_LOW) || (r_state == ST_HIGH);
    assign w_last   = (r_bit_cnt == 3'd7);
    assign w_div_m1 = cpu.fast_sel ? FAST_M1 : SLOW_M1;

`ifdef SD_SPI_LOOPBACK_EN
    assign w_rx_in = i_loop_en ? r_mosi : i_sd_miso;
`else
    assign w_rx_in = i_sd_miso;
`endif

    spi_halfper_cnt #(
        .CNT_W (CNT_W)
    ) u_halfper (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_load   (w_start),
        .i_div_m1 (w_div_m1),
        .i_en     (w_busy),
        .o_tick   (w_tick)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        unique case (r_state)
            // FINISH accepts a new strobe so back-to-back bytes have no idle gap
            ST_IDLE, ST_FINISH: begin
                if (cpu.wr_stb) begin
                    w_start      = 1'b1;
                    w_state_next = ST_LOW;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (w_tick) begin
                    w_state_next = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (w_tick) begin
                    w_state_next = w_last ? ST_FINISH : ST_LOW;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_shift   <= '0;
            r_rx_bit  <= 1'b0;
            r_bit_cnt <= '0;
            r_sclk    <= 1'b0;
            r_mosi    <= SPI_IDLE_MOSI;
            r_cs_n    <= 1'b1;
            r_rd_data <= RD_RESET;
        end else begin
            r_cs_n <= ~cpu.cs_ctl;
            if (w_start) begin
                r_shift   <= cpu.wr_data[6:0];
                r_mosi    <= cpu.wr_data[7];
                r_bit_cnt <= '0;
            end else if ((r_state == ST_LOW) && w_tick) begin
                r_sclk   <= 1'b1;
                r_rx_bit <= w_rx_in;
            end else if ((r_state == ST_HIGH) && w_tick) begin
                r_sclk <= 1'b0;
                if (w_last) begin
                    r_rd_data <= {r_shift, r_rx_bit};
                    r_mosi    <= SPI_IDLE_MOSI;
                end else begin
                    r_mosi    <= r_shift[6];
                    r_shift   <= {r_shift[5:0], r_rx_bit};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
            end
        end
    end

    assign cpu.rd_data = r_rd_data;
    assign cpu.busy    = w_busy;
    assign cpu.done    = (r_state == ST_FINISH);
    assign o_sd_cs_n   = r_cs_n;
    assign o_sd_sclk   = r_sclk;
    assign o_sd_mosi   = r_mosi;

endmodule
